// File: rtl/mul_vector_seq.sv
// Sequential schoolbook multiplier over LIMBS limbs of W bits: one partial product per cycle
// into a wide accumulator, with valid/ready handshakes and an optional low-half-only mode.
module mul_vector_seq #(
    parameter int unsigned W     = 16,
    parameter int unsigned LIMBS = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [LIMBS*W-1:0]       a,
    input  logic [LIMBS*W-1:0]       b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*LIMBS*W-1:0]     y
);

    localparam int unsigned HW = LIMBS * W;
    localparam int unsigned AW = 2 * HW;
    localparam int unsigned CW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

    localparam logic [CW-1:0] LAST     = CW'(LIMBS - 1);
    localparam logic [AW-1:0] LOW_MASK = AW'({HW{1'b1}});

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] a_q, a_d, b_q, b_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] acc_q, acc_d, y_q, y_d;
    logic [CW-1:0] i_q, i_d, j_q, j_d;

    logic [W-1:0]   a_limb, b_limb;
    logic [2*W-1:0] pp;
    logic [AW-1:0]  acc_sum;
    logic [CW-1:0]  j_lim;
    int unsigned    shamt;

    always_comb begin
        a_limb  = a_q[i_q*W +: W];
        b_limb  = b_q[j_q*W +: W];
        pp      = {{W{1'b0}}, a_limb} * {{W{1'b0}}, b_limb};
        shamt   = (int'(i_q) + int'(j_q)) * W;
        // Carry out of the top limb is discarded: acc is modulo 2^AW.
        acc_sum = acc_q + (AW'(pp) << shamt);
        // Low-half mode skips every pair whose product lands entirely above limb LIMBS-1.
        j_lim   = mode_q ? (LAST - i_q) : LAST;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        y_d     = y_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_d = acc_sum;
                if (j_q == j_lim) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        state_d = DONE;
                        y_d     = mode_q ? (acc_sum & LOW_MASK) : acc_sum;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            y_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

endmodule

// File: tb/tb_mul_vector_seq.sv
// Directed bench for mul_vector_seq: a 2x16-bit instance for the hand-computed cases and an
// 3x8-bit instance for a randomised sweep against a bench-side product.
module tb_mul_vector_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, mode, out_valid, out_ready;
    logic [31:0] a, b;
    logic [63:0] y;

    logic        in_valid3, in_ready3, mode3, out_valid3, out_ready3;
    logic [23:0] a3, b3;
    logic [47:0] y3;

    int vectors = 0;
    int errors  = 0;

    mul_vector_seq #(.W(16), .LIMBS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    mul_vector_seq #(.W(8), .LIMBS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .mode(mode3),
        .a(a3), .b(b3), .out_valid(out_valid3), .out_ready(out_ready3), .y(y3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one operation on the 2x16 instance, scramble the inputs, return cycles to out_valid.
    task automatic run16(input logic [31:0] av, input logic [31:0] bv, input logic md,
                         output int lat);
        a = av; b = bv; mode = md; in_valid = 1'b1;
        check("accept_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; mode = ~md;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            check("busy_in_ready", 64'(in_ready), 64'd0);
            tick();
            lat++;
        end
    endtask

    task automatic run3(input logic [23:0] av, input logic [23:0] bv, input logic md,
                        input string tag);
        int lat;
        logic [47:0] exp;
        exp = 48'(av) * 48'(bv);
        if (md) exp = exp & 48'hFF_FFFF;
        a3 = av; b3 = bv; mode3 = md; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        a3 = ~av; b3 = ~bv;
        lat = 0;
        while (out_valid3 !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), md ? 64'd6 : 64'd9);
        check({tag, "_y"}, 64'(y3), 64'(exp));
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
    endtask

    initial begin
        int lat;
        logic [63:0] held;
        logic [23:0] ra, rb;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; a = '0; b = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b0; mode3 = 1'b0; a3 = '0; b3 = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_y", y, 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic full product.
        out_ready = 1'b1;
        run16(32'h0001_0002, 32'h0003_0004, 1'b0, lat);
        check("full_lat", 64'(lat), 64'd4);
        check("full_y", y, 64'h0000_0003_000A_0008);
        tick();
        check("full_consumed_valid", 64'(out_valid), 64'd0);
        check("full_consumed_ready", 64'(in_ready), 64'd1);

        // All-ones: carries ripple through the accumulator.
        run16(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
        check("ones_lat", 64'(lat), 64'd4);
        check("ones_y", y, 64'hFFFF_FFFE_0000_0001);
        tick();

        // Low-half mode.
        run16(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
        check("low_lat", 64'(lat), 64'd3);
        check("low_y", y, 64'h0000_0000_0000_0001);
        tick();

        // Backpressure in DONE with noisy inputs.
        out_ready = 1'b0;
        run16(32'h0001_0002, 32'h0003_0004, 1'b0, lat);
        check("bp_lat", 64'(lat), 64'd4);
        held = y;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            a = $urandom; b = $urandom;
            tick();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_y", y, 64'h0000_0003_000A_0008);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_drain_valid", 64'(out_valid), 64'd0);
        check("bp_drain_ready", 64'(in_ready), 64'd1);
        check("bp_y_held", y, held);
        tick();
        check("bp_no_capture", 64'(in_ready), 64'd1);

        // Reset two cycles into MUL, then a fresh operation.
        out_ready = 1'b0;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_y", y, 64'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        run16(32'h0000_0005, 32'h0000_0007, 1'b0, lat);
        check("postrst_lat", 64'(lat), 64'd4);
        check("postrst_y", y, 64'h0000_0000_0000_0023);
        tick();
        out_ready = 1'b0;

        // 3x8 instance: zero operands, extremes, then random sweep in both modes.
        run3(24'h00_0000, 24'hAB_CDEF, 1'b0, "p3_zero");
        run3(24'hFF_FFFF, 24'hFF_FFFF, 1'b0, "p3_ones_full");
        run3(24'hFF_FFFF, 24'hFF_FFFF, 1'b1, "p3_ones_low");
        for (int n = 0; n < 200; n++) begin
            ra = 24'($urandom);
            rb = 24'($urandom);
            run3(ra, rb, 1'b0, "p3_rand_full");
            run3(ra, rb, 1'b1, "p3_rand_low");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mul_vector_seq.md
Name: mul_vector_seq

Overview:
- Sequential schoolbook multiplier for multi-limb vectors. Operands are LIMBS limbs of W bits each; the product is 2*LIMBS limbs.
- Generalises the fixed 2x16-bit combinational vector multiplier cell to any limb width and limb count.
- Adds a valid/ready handshake and a low-half-only mode.
- Computes one partial product per cycle into a wide accumulator. Used as the reference-quality multiplier engine in the vector-multiply datapath.

Parameters:
- W, 16, limb width in bits (>=1)
- LIMBS, 2, limbs per operand (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand presented
- in_ready  output  1  block can accept operands
- mode  input  1  0 = full 2*LIMBS-limb product; 1 = low LIMBS limbs only
- a  input  LIMBS*W  operand A, limb i at bits [i*W +: W], limb 0 least significant
- b  input  LIMBS*W  operand B, same packing
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- y  output  2*LIMBS*W  product, limb k at bits [k*W +: W]

Behaviour:
- One clock domain. Reset is asynchronous, active-low.
- Under reset:
  - state=IDLE
  - acc, y, the operand registers and the i/j counters all cleared to 0
  - out_valid=0
- States:
  - IDLE: in_ready=1, out_valid=0
  - MUL: in_ready=0, out_valid=0
  - DONE: in_ready=0, out_valid=1
- in_ready and out_valid are decoded from the state register only. No combinational path from in_valid or out_ready.
- IDLE -> MUL on the edge where in_valid && in_ready:
  - a, b and mode are captured.
  - acc cleared; i=0, j=0.
  - Later changes on a, b or mode are ignored until the next accept.
- MUL, each cycle:
  - acc += zero-extend(a[i]*b[j]) << ((i+j)*W).
  - The product is 2W bits wide; acc is 2*LIMBS*W bits; any carry out of acc is discarded (acc is modulo 2^(2*LIMBS*W)).
  - Inner index j advances first.
  - mode=0: j runs 0..LIMBS-1 for each i, i runs 0..LIMBS-1. L_full = LIMBS*LIMBS cycles.
  - mode=1: j runs 0..LIMBS-1-i only, so pairs with i+j>=LIMBS are skipped. L_low = LIMBS*(LIMBS+1)/2 cycles.
  - In mode=1, acc is truncated to its low LIMBS*W bits when loaded into y; the upper limbs of y are 0.
- MUL -> DONE on the edge performing the final MAC. y is loaded from the final accumulated value (including that MAC) on the same edge.
- Timing: with acceptance on edge E0, out_valid is first high after edge E(L), where L = L_full or L_low.
- DONE -> IDLE on the edge where out_ready=1.
- y holds its value after the handshake until the next DONE entry. y is never observed changing while out_valid=1.
- Back-to-back operation: a new accept can occur at the earliest on the edge after DONE -> IDLE. Throughput is one result per L+2 cycles.
- Boundary conditions:
  - LIMBS=1: L_full = L_low = 1.
  - Operands of 0: y=0 after full latency. No early exit, so latency is data-independent.
  - in_valid high in MUL or DONE: ignored, not captured.
  - out_ready high in IDLE or MUL: no effect.
  - Reset asserted mid-MUL or in DONE: the result is lost; outputs take their reset values immediately, asynchronously. After rst_n rises, the first accept is possible on the first clock edge.

Test Plan:
- Full product, W=16 and LIMBS=2 throughout:
  - Stimulus: a=0x0001_0002, b=0x0003_0004, mode=0, out_ready=1.
  - Response: out_valid rises 4 cycles after accept; y3..y0 = 0x0000, 0x0003, 0x000A, 0x0008.
- All-ones corner:
  - Stimulus: a=b=0xFFFF_FFFF, mode=0.
  - Response: y = 0xFFFF, 0xFFFE, 0x0000, 0x0001 (carry propagation through the accumulator).
- Low-half mode:
  - Stimulus: same all-ones operands, mode=1.
  - Response: out_valid after 3 cycles; y = 0x0000, 0x0000, 0x0000, 0x0001.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE, toggling a, b and in_valid throughout.
  - Response: out_valid and y stay stable; in_ready=0; no new capture. Result is consumed on the first out_ready=1 edge; in_ready=1 on the next cycle.
- Reset mid-operation:
  - Stimulus: drop rst_n 2 cycles into MUL.
  - Response: out_valid=0, y=0, in_ready=1 immediately. After release, a fresh accept of a=0x0000_0005, b=0x0000_0007 gives y0=0x0023, all other limbs 0.
- Parameter sweep:
  - Stimulus: W=8, LIMBS=3 with 200 random operand pairs in both modes.
  - Response: y matches a*b (mode=0) or (a*b) mod 2^24 (mode=1); latency 9 or 6 cycles respectively.
